unid_load_store: RTL

- Initiator side of the data-memory interface: the RV32I load/store unit between the core and the word-wide data memory.
- Memory has asynchronous read and synchronous write. It addresses whole words with address bits [9:2] and has no byte enables.
- This unit performs all load/store widths (lb, lh, lw, lbu, lhu, sb, sh, sw) with a request/response handshake to the core.
- Sub-word stores use read-modify-write.

---
 rtl/unid_load_store.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/unid_load_store.sv
// RV32I load/store unit: drives a word-wide, byte-enable-less data memory and
// performs sub-word stores by read-modify-write. Optional macro: MISALIGN_TRAP_EN.
module unid_load_store #(
  parameter int LARGURA_DADO = 32
) (
  input  logic                    sinal_clk,
  input  logic                    sinal_rst,
  input  logic                    req_valida,
  output logic                    req_pronta,
  input  logic                    operacao_escrita,
  input  logic [2:0]              funct3,
  input  logic [LARGURA_DADO-1:0] endereco,
  input  logic [LARGURA_DADO-1:0] dado_store,
  output logic                    resp_valida,
  output logic [LARGURA_DADO-1:0] dado_load,
  output logic                    erro_alinhamento,
  output logic                    mem_habilitar_escrita,
  output logic [LARGURA_DADO-1:0] mem_endereco,
  output logic [LARGURA_DADO-1:0] mem_dado_escrita,
  input  logic [LARGURA_DADO-1:0] mem_dado_leitura
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    LEITURA  = 2'd1,
    ESCRITA  = 2'd2,
    RESPOSTA = 2'd3
  } estado_t;

  estado_t           estado_q, estado_d;
  logic              escrita_q, escrita_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [31:0]       end_q, end_d;
  logic [31:0]       dado_q, dado_d;
  logic [31:0]       load_q, load_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              erro_q, erro_d;
  logic              desalinhado_s;

  // funct3[1:0]: 00 byte, 01 half, 1x word (covers the undefined codes too)
  function automatic logic [31:0] extrai_load(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  extrai_load = {{24{b[7]}}, b};
      3'b001:  extrai_load = {{16{h[15]}}, h};
      3'b100:  extrai_load = {24'd0, b};
      3'b101:  extrai_load = {16'd0, h};
      default: extrai_load = w;
    endcase
  endfunction

  function automatic logic [31:0] mescla_store(input logic [2:0] f3,
                                               input logic [1:0] off,
                                               input logic [31:0] antigo,
                                               input logic [31:0] st);
    logic [31:0] r;
    r = antigo;
    case (f3[1:0])
      2'b00: begin
        case (off)
          2'd0:    r[7:0]   = st[7:0];
          2'd1:    r[15:8]  = st[7:0];
          2'd2:    r[23:16] = st[7:0];
          2'd3:    r[31:24] = st[7:0];
          default: r[7:0]   = st[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          r[31:16] = st[15:0];
        end else begin
          r[15:0] = st[15:0];
        end
      end
      default: r = st;
    endcase
    mescla_store = r;
  endfunction

  // Misalignment detection on the incoming request
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    desalinhado_s = ((funct3[1:0] == 2'b01) && endereco[0]) ||
                    (funct3[1] && (endereco[1:0] != 2'b00));
`else
    desalinhado_s = 1'b0;
`endif
  end

  // Next-state and datapath update
  always_comb begin
    estado_d  = estado_q;
    escrita_d = escrita_q;
    funct3_d  = funct3_q;
    end_d     = end_q;
    dado_d    = dado_q;
    load_d    = load_q;
    wdata_d   = wdata_q;
    erro_d    = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (req_valida) begin
          escrita_d = operacao_escrita;
          funct3_d  = funct3;
          end_d     = endereco;
          dado_d    = dado_store;
          wdata_d   = dado_store;
          if (desalinhado_s) begin
            erro_d   = 1'b1;
            estado_d = RESPOSTA;
          end else if (operacao_escrita && funct3[1]) begin
            estado_d = ESCRITA;
          end else begin
            estado_d = LEITURA;
          end
        end else begin
          estado_d = OCIOSO;
        end
      end
      LEITURA: begin
        if (escrita_q) begin
          wdata_d  = mescla_store(funct3_q, end_q[1:0], mem_dado_leitura, dado_q);
          estado_d = ESCRITA;
        end else begin
          load_d   = extrai_load(funct3_q, end_q[1:0], mem_dado_leitura);
          estado_d = RESPOSTA;
        end
      end
      ESCRITA:  estado_d = RESPOSTA;
      RESPOSTA: estado_d = OCIOSO;
      default:  estado_d = OCIOSO;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge sinal_clk or posedge sinal_rst) begin
    if (sinal_rst) begin
      estado_q  <= OCIOSO;
      escrita_q <= 1'b0;
      funct3_q  <= 3'd0;
      end_q     <= 32'd0;
      dado_q    <= 32'd0;
      load_q    <= 32'd0;
      wdata_q   <= 32'd0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      escrita_q <= escrita_d;
      funct3_q  <= funct3_d;
      end_q     <= end_d;
      dado_q    <= dado_d;
      load_q    <= load_d;
      wdata_q   <= wdata_d;
      erro_q    <= erro_d;
    end
  end

  // Strobes decode straight from the state flop so reset kills them at once
  assign req_pronta            = (estado_q == OCIOSO);
  assign resp_valida           = (estado_q == RESPOSTA);
  assign mem_habilitar_escrita = (estado_q == ESCRITA);
  assign erro_alinhamento      = erro_q;
  assign mem_endereco          = {end_q[31:2], 2'b00};
  assign mem_dado_escrita      = wdata_q;
  assign dado_load             = load_q;

endmodule
